// File: rtl/load_store_unit.sv
// load_store_unit: the core-side load/store engine for a single-port, word-wide
// data memory whose read data is registered one cycle after mem_read_enable.
// Byte and halfword stores are done as a read-modify-write of the whole word.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are rejected. When it is not defined, the low address bits
// are cleared so the access is aligned.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. Each accepted request produces exactly one
// single-cycle rsp_valid pulse, and rsp_err qualifies that pulse.
module load_store_unit #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_DATA, S_ST_WR, S_RMW_RD, S_RMW_WR, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        misalign;
  logic        illegal;
  logic [31:0] addr_aligned;
  logic [31:0] ld_result;
  logic [31:0] merged;

  // Request decode: legality checks and address alignment.
  always_comb begin
    accept   = req_valid && (state_q == S_IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    illegal  = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= DEPTH_U) || misalign;
    // Clearing the low bits is harmless in the trap build, because misaligned
    // requests never reach memory there.
    addr_aligned = req_addr;
    if (req_size == 2'b01) addr_aligned[0]   = 1'b0;
    if (req_size == 2'b10) addr_aligned[1:0] = 2'b00;
  end

  // Load lane extraction and store lane merge from the registered memory word.
  always_comb begin
    ld_result = mem_data_out;
    merged    = mem_data_out;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0: begin ld_result = {{24{~unsigned_q & mem_data_out[7]}},  mem_data_out[7:0]};   merged[7:0]   = wdata_q[7:0]; end
          2'd1: begin ld_result = {{24{~unsigned_q & mem_data_out[15]}}, mem_data_out[15:8]};  merged[15:8]  = wdata_q[7:0]; end
          2'd2: begin ld_result = {{24{~unsigned_q & mem_data_out[23]}}, mem_data_out[23:16]}; merged[23:16] = wdata_q[7:0]; end
          default: begin ld_result = {{24{~unsigned_q & mem_data_out[31]}}, mem_data_out[31:24]}; merged[31:24] = wdata_q[7:0]; end
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          ld_result = {{16{~unsigned_q & mem_data_out[31]}}, mem_data_out[31:16]};
          merged[31:16] = wdata_q[15:0];
        end else begin
          ld_result = {{16{~unsigned_q & mem_data_out[15]}}, mem_data_out[15:0]};
          merged[15:0] = wdata_q[15:0];
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (illegal)                 state_d = S_ERR;
          else if (!req_we)            state_d = S_LD_REQ;
          else if (req_size == 2'b10)  state_d = S_ST_WR;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LD_REQ:  state_d = S_LD_DATA;
      S_LD_DATA: state_d = S_IDLE;
      S_ST_WR:   state_d = S_IDLE;
      S_RMW_RD:  state_d = S_RMW_WR;
      S_RMW_WR:  state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and response next values.
  always_comb begin
    addr_d      = addr_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    if (accept) begin
      addr_d     = addr_aligned;
      size_d     = req_size;
      unsigned_d = req_unsigned;
      wdata_d    = req_wdata;
      // The error response is raised at the acceptance edge, so that it lands
      // one cycle after acceptance. This coincides with the single ERR cycle.
      rsp_valid_d = illegal;
      rsp_err_d   = illegal;
    end
    if (state_q == S_LD_DATA) rsp_rdata_d = ld_result;
    if ((state_q == S_LD_DATA) || (state_q == S_ST_WR) || (state_q == S_RMW_WR))
      rsp_valid_d = 1'b1;
  end

  // Output decode from the current state; reset forces the strobes low at once.
  always_comb begin
    req_ready        = (state_q == S_IDLE);
    mem_read_enable  = (state_q == S_LD_REQ) || (state_q == S_RMW_RD);
    mem_write_enable = (state_q == S_ST_WR)  || (state_q == S_RMW_WR);
    mem_address      = {2'b00, addr_q[31:2]};
    mem_data_in      = (state_q == S_RMW_WR) ? merged : wdata_q;
    rsp_valid        = rsp_valid_q;
    rsp_err          = rsp_err_q;
    rsp_rdata        = rsp_rdata_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
